// File: rtl/soc_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte-count/lane-mask helpers and the store-data lane rotation.
package soc_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT1 = 2'b01,
    RESP  = 2'b10
  } lsu_state_e;

  function automatic logic [2:0] lsu_bytes(input lsu_size_e size);
    logic [2:0] n;
    case (size)
      BYTE:    n = 3'd1;
      HALF:    n = 3'd2;
      WORD:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Bits [3:0] are the first word's lanes, bits [7:4] spill into the next word.
  function automatic logic [7:0] lsu_mask8(input lsu_size_e size, input logic [1:0] off);
    logic [7:0] base;
    base = 8'((9'd1 << lsu_bytes(size)) - 9'd1);
    return base << off;
  endfunction

  function automatic logic [31:0] lsu_rotl(input logic [31:0] data, input logic [1:0] off);
    logic [31:0] r;
    case (off)
      2'd0:    r = data;
      2'd1:    r = {data[23:0], data[31:24]};
      2'd2:    r = {data[15:0], data[31:16]};
      default: r = {data[7:0],  data[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soc_lsu_align.sv
// Load data assembly: merges the held first beat with the current beat for
// split accesses, trims to the access size and sign/zero-extends.
module soc_lsu_align
  import soc_lsu_pkg::*;
(
  input  logic [31:0] i_rvalue,
  input  logic [31:0] i_hold,
  input  logic        i_split,
  input  logic [1:0]  i_off,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_raw;

  // Lanes below 4-off were delivered by the first beat of a split access.
  always_comb begin
    w_raw = i_rvalue;
    for (int j = 0; j < 4; j++) begin
      if (i_split && ((3'(j) + {1'b0, i_off}) < 3'd4)) begin
        w_raw[8*j +: 8] = i_hold[8*j +: 8];
      end
    end
  end

  always_comb begin
    o_data = w_raw;
    case (i_size)
      BYTE:    o_data = i_unsigned ? {24'b0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
      HALF:    o_data = i_unsigned ? {16'b0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/soc_lsu.sv
// Load/store unit: turns core requests into SoC bus beats and returns aligned data.
// Define SOC_LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
module soc_lsu
  import soc_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        bus_enable_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_addr_prev_o,
  output logic [31:0] bus_wvalue_o,
  input  logic [31:0] bus_rvalue_i
);

  lsu_state_e  r_state, w_next;
  logic [31:0] r_addr, r_addr_prev;
  lsu_size_e   r_size;
  logic        r_we, r_unsigned, r_err;

  lsu_size_e   w_req_size;
  logic [7:0]  w_req_mask8;
  logic        w_req_cross, w_req_err, w_hs;
  logic [31:0] w_hold, w_load_data;
  logic        w_split;

  assign w_req_size  = lsu_size_e'(req_size_i);
  assign w_req_mask8 = lsu_mask8(w_req_size, req_addr_i[1:0]);
  assign w_req_cross = |w_req_mask8[7:4];
  assign w_hs        = req_valid_i && (r_state == IDLE);

`ifdef SOC_LSU_MISALIGNED_EN
  logic [31:0] r_hold, r_wdata;
  logic [3:0]  r_strb1;

  assign w_req_err = (w_req_size == RSVD);
  assign w_hold    = r_hold;
  assign w_split   = |r_strb1;

  // Second-beat context, plus the first beat's data arriving during BEAT1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold  <= '0;
      r_wdata <= '0;
      r_strb1 <= '0;
    end else begin
      if (w_hs) begin
        r_wdata <= req_wdata_i;
        r_strb1 <= w_req_mask8[7:4];
      end
      if (r_state == BEAT1) r_hold <= bus_rvalue_i;
    end
  end
`else
  assign w_req_err = (w_req_size == RSVD) || w_req_cross;
  assign w_hold    = '0;
  assign w_split   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_addr_prev <= '0;
      r_addr      <= '0;
      r_size      <= BYTE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_addr_prev <= bus_addr_o;
      if (w_hs) begin
        r_addr     <= req_addr_i;
        r_size     <= w_req_size;
        r_we       <= req_we_i;
        r_unsigned <= req_unsigned_i;
        r_err      <= w_req_err;
      end
    end
  end

  assign bus_addr_prev_o = r_addr_prev;

  soc_lsu_align u_align (
    .i_rvalue   (bus_rvalue_i),
    .i_hold     (w_hold),
    .i_split    (w_split),
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  // Beat0 goes out combinationally in the handshake cycle; rejected requests issue no beat.
  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    bus_enable_o = 1'b0;
    bus_wstrb_o  = 4'b0;
    bus_addr_o   = r_addr;
    bus_wvalue_o = '0;
    rsp_valid_o  = 1'b0;
    rsp_err_o    = 1'b0;
    rsp_rdata_o  = '0;
    unique case (r_state)
      IDLE: begin
        req_ready_o  = 1'b1;
        bus_addr_o   = req_addr_i;
        bus_wvalue_o = lsu_rotl(req_wdata_i, req_addr_i[1:0]);
        if (req_valid_i) begin
          w_next = RESP;
          if (!w_req_err) begin
            bus_enable_o = 1'b1;
            bus_wstrb_o  = req_we_i ? w_req_mask8[3:0] : 4'b0;
`ifdef SOC_LSU_MISALIGNED_EN
            if (w_req_cross) w_next = BEAT1;
`endif
          end
        end
      end
`ifdef SOC_LSU_MISALIGNED_EN
      BEAT1: begin
        bus_enable_o = 1'b1;
        bus_addr_o   = r_addr + 32'd4;
        bus_wstrb_o  = r_we ? r_strb1 : 4'b0;
        bus_wvalue_o = lsu_rotl(r_wdata, r_addr[1:0]);
        w_next       = RESP;
      end
`endif
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = r_err;
        rsp_rdata_o = (r_we || r_err) ? '0 : w_load_data;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_lsu.sv
// Directed bench for soc_lsu with a byte-lane memory responder and a response scoreboard;
// expectations follow SOC_LSU_MISALIGNED_EN when it is defined for the build.
module tb_soc_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        bus_enable_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_addr_prev_o;
  logic [31:0] bus_wvalue_o;
  logic [31:0] bus_rvalue_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [0:255];
  logic        preloaded = 1'b0;

  soc_lsu dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_size_i      (req_size_i),
    .req_unsigned_i  (req_unsigned_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .bus_enable_o    (bus_enable_o),
    .bus_wstrb_o     (bus_wstrb_o),
    .bus_addr_o      (bus_addr_o),
    .bus_addr_prev_o (bus_addr_prev_o),
    .bus_wvalue_o    (bus_wvalue_o),
    .bus_rvalue_i    (bus_rvalue_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rotr(input logic [31:0] d, input logic [1:0] o);
    int sh;
    sh = 8 * int'(o);
    return (d >> sh) | (d << (32 - sh));
  endfunction

  // Responder: byte-lane writes on the clock edge, reads rotated by the previous address.
  always @(posedge clk_i) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h40] <= 32'h44332211;
      mem[8'h41] <= 32'h88776655;
      preloaded  <= 1'b1;
    end else if (bus_enable_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_wstrb_o[b]) mem[bus_addr_o[9:2]][8*b +: 8] <= bus_wvalue_o[8*b +: 8];
      end
    end
  end

  assign bus_rvalue_i = rotr(mem[bus_addr_prev_o[9:2]], bus_addr_prev_o[1:0]);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request: checks beat0 in the handshake cycle, beat1 if split, then the scoreboarded response.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic expBeat, input logic expSplit,
                               input logic [3:0] expStrb0, input logic [3:0] expStrb1,
                               input logic [31:0] expWvalue,
                               input logic [31:0] expRdata, input logic expErr);
    int   cyc;
    logic got;
    exp_t e;
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    #1;
    checkOutput({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    checkOutput({tag, "_en0"}, {31'b0, bus_enable_o}, {31'b0, expBeat});
    if (expBeat) begin
      checkOutput({tag, "_addr0"}, bus_addr_o, addr);
      checkOutput({tag, "_strb0"}, {28'b0, bus_wstrb_o}, {28'b0, expStrb0});
      if (we) checkOutput({tag, "_wval0"}, bus_wvalue_o, expWvalue);
    end
    sbq.push_back('{rdata: expRdata, err: expErr});
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 6) begin
      @(negedge clk_i);
      cyc++;
      if (expSplit && cyc == 1) begin
        checkOutput({tag, "_en1"}, {31'b0, bus_enable_o}, 32'd1);
        checkOutput({tag, "_addr1"}, bus_addr_o, addr + 32'd4);
        checkOutput({tag, "_strb1"}, {28'b0, bus_wstrb_o}, {28'b0, expStrb1});
        if (we) checkOutput({tag, "_wval1"}, bus_wvalue_o, expWvalue);
      end
      if (rsp_valid_o) begin
        got = 1'b1;
        checkOutput({tag, "_lat"}, 32'(cyc), expSplit ? 32'd2 : 32'd1);
        checkOutput({tag, "_rspen"}, {31'b0, bus_enable_o}, 32'd0);
        if (sbq.size() == 0) begin
          checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          checkOutput({tag, "_rdata"}, rsp_rdata_o, e.rdata);
          checkOutput({tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, e.err});
        end
      end
    end
    if (!got) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk_i);
    #1;
    checkOutput("rst_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_err", {31'b0, rsp_err_o}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
    checkOutput("rst_prev", bus_addr_prev_o, 32'd0);
    checkOutput("rst_en", {31'b0, bus_enable_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus("lb107",  1'b0, 2'b00, 1'b0, 32'h107, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'hFFFFFF88, 1'b0);
    applyStimulus("lbu107", 1'b0, 2'b00, 1'b1, 32'h107, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h00000088, 1'b0);
    applyStimulus("lh101",  1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h00003322, 1'b0);
    applyStimulus("lw100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h44332211, 1'b0);
    applyStimulus("lhu106", 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h00008877, 1'b0);
`ifdef SOC_LSU_MISALIGNED_EN
    applyStimulus("lw102",  1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 32'h66554433, 1'b0);
    applyStimulus("sh103",  1'b1, 2'b01, 1'b0, 32'h103, 32'h0000BEEF, 1'b1, 1'b1, 4'b1000, 4'b0001, 32'hEF0000BE, 32'h0, 1'b0);
    applyStimulus("lh103",  1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 32'hFFFFBEEF, 1'b0);
`else
    applyStimulus("lw102",  1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus("sh103",  1'b1, 2'b01, 1'b0, 32'h103, 32'h0000BEEF, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus("lh103",  1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1);
`endif
    applyStimulus("sb101",  1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 1'b1, 1'b0, 4'b0010, 4'h0, 32'h0000A500, 32'h0, 1'b0);
    applyStimulus("lbu101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h000000A5, 1'b0);
`ifdef SOC_LSU_MISALIGNED_EN
    applyStimulus("lw100b", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'hEF33A511, 1'b0);
`else
    applyStimulus("lw100b", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h4433A511, 1'b0);
`endif
    applyStimulus("rsvd",   1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Reset one cycle after a crossing request's handshake: its response must never appear.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_size_i  = 2'b10;
    req_addr_i  = 32'h102;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("midrst_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("midrst_prev", bus_addr_prev_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("postrst_prev", bus_addr_prev_o, 32'd0);
    checkOutput("postrst_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("postrst_novalid", {31'b0, rsp_valid_o}, 32'd0);
    end

`ifdef SOC_LSU_MISALIGNED_EN
    applyStimulus("lw104",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h887766BE, 1'b0);
`else
    applyStimulus("lw104",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 32'h88776655, 1'b0);
`endif
    checkOutput("sb_drain", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
